fifo_drain_stage: RTL
=====================

# fifo_drain_stage

Downstream consumer for the pointer-managed buffer stage. It pops words from the buffer's show-ahead read port (data valid whenever not empty), re-times them through a 2-entry output queue and presents them on a valid/ready stream. Each word is tagged with a burst-end flag every BURST_LEN words. Full throughput is sustained with no combinational path from `out_ready` to `fifo_rd_en`.

## Interface
- WIDTH, 16, data width; must match the upstream buffer stage.
- BURST_LEN, 4, words per burst; legal range 1..65535.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  permits new pops from the FIFO; queued words drain regardless.
- fifo_empty  input  1  upstream buffer empty flag.
- fifo_data  input  WIDTH  upstream head word; valid in the same cycle whenever `fifo_empty`=0.
- fifo_rd_en  output  1  pop strobe to upstream; the word on `fifo_data` is consumed this cycle.
- out_valid  output  1  output word available.
- out_ready  input  1  downstream accepts the word when high together with `out_valid`.
- out_data  output  WIDTH  output word.
- out_last  output  1  final word of a burst.
- burst_done  output  1  one-cycle pulse, registered, the cycle after a beat with `out_last`=1 is accepted.
- busy  output  1  high when queue occupancy is non-zero or a burst is partially popped.

## Operation
- Queue: 2 entries of {data, last}. Occupancy `occ` takes values 0..2.
- Pop rule: `fifo_rd_en = !rst && enable && !fifo_empty && (occ < 2)`.
  - Purely a function of registered state and upstream flags.
  - Never depends on `out_ready`.
- Pop counter `pop_cnt` (16 bits):
  - Each popped word is tagged last = (`pop_cnt` == BURST_LEN-1).
  - `pop_cnt` increments on each pop and wraps to 0 after the tagged word.
  - With BURST_LEN=1, every word is last.
- Accept = `out_valid && out_ready`. On accept, the head entry retires.
- Occupancy update:
  - Simultaneous pop and accept: `occ` unchanged; the pushed word goes behind the remaining entry.
  - Pop only: `occ`+1.
  - Accept only: `occ`-1.
- Ordering is strictly FIFO. `out_data`/`out_last` always reflect the head entry.
- `out_valid` = (`occ` != 0).
- While `out_valid`=1 and not accepted, `out_data` and `out_last` hold stable.
- `busy` = (`occ` != 0) || (`pop_cnt` != 0).
- Deasserting `enable` mid-burst:
  - Pops stop and `pop_cnt` is held.
  - Queued words still drain.
  - When `enable` returns, the burst resumes at the held count.
- Upstream `fifo_empty` mid-burst is handled the same way: the partial burst waits. No timeout or flush exists.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `burst_done`=0, `busy`=0, `fifo_rd_en`=0.
- Reset clears `occ` and `pop_cnt`. Reset asserted mid-burst discards queued words and restarts framing at word 0.
- Latency: a word popped in cycle N is presented on `out_data` in cycle N+1 (when `occ` was 0).
- Throughput: with `out_ready` held high and the FIFO non-empty, one word per cycle; `occ` settles at 1.
- Downstream stall:
  - With `out_ready`=0, at most 2 further pops occur (occ 0→2).
  - `fifo_rd_en` then drops in the cycle after `occ` reaches 2.
  - When `out_ready` rises, `occ` becomes 1 and popping resumes the next cycle.
- `burst_done` asserts for exactly one cycle, in cycle N+1 after a last-beat accept in cycle N.

## Configuration
- Macro `FIFO_DRAIN_STATS_EN`.
- Defined: adds two outputs.
  - `beat_count` [31:0]: accepted beats.
  - `burst_count` [15:0]: accepted last-beats.
  - Both are registered, reset to 0, increment on accept, and wrap modulo 2^32 / 2^16.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset, then BURST_LEN=4, FIFO preloaded with 0x0001..0x0008, `out_ready`=1, `enable`=1:
  - First `out_valid` one cycle after the first pop.
  - 8 consecutive beats.
  - `out_last` on 0x0004 and 0x0008.
  - Two `burst_done` pulses.
  - `busy`=0 at the end.
- `out_ready`=0 for 10 cycles with the FIFO holding 6 words:
  - Exactly 2 pops.
  - `out_data` stable at the first word.
  - On release, all 6 words arrive in order with no duplicates or loss.
- `enable` dropped after 2 words of a 4-word burst:
  - Pops stop and `busy` stays 1.
  - Re-enabling yields words 3 and 4, with `out_last` on word 4.
- BURST_LEN=1: every beat has `out_last`=1, and `burst_done` pulses after each accepted beat.
- Reset asserted with `occ`=2 mid-burst:
  - Next cycle `out_valid`=0 and `fifo_rd_en`=0.
  - After release, the next burst's last lands on the 4th new word.
- `FIFO_DRAIN_STATS_EN` defined, 9 accepts at BURST_LEN=4: `beat_count`=9, `burst_count`=2. Random `out_ready` toggling gives the same totals.

Source files
------------

// File: rtl/fifo_drain_stage.sv
// -----------------------------------------------------------------------------
// fifo_drain_stage
//
// Consumer for a show-ahead buffer (head word valid whenever not empty).
// Words are popped into a 2-entry output queue, tagged with a burst-end flag
// every BURST_LEN words, and presented on a valid/ready stream.
//
// The pop strobe depends only on registered occupancy and the upstream flags.
// There is no combinational path from out_ready to fifo_rd_en. The second
// queue entry is what lets the stage sustain one word per cycle without that
// path.
//
// Parameters
//   WIDTH      data width, must match the upstream buffer
//   BURST_LEN  words per burst, 1..65535
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       permits new pops; words already queued drain regardless
//   fifo_empty   upstream empty flag
//   fifo_data    upstream head word, valid whenever fifo_empty = 0
//   fifo_rd_en   pop strobe; fifo_data is consumed in this cycle
//   out_valid    head entry available
//   out_ready    downstream accept
//   out_data     head entry data (0 while the queue is empty)
//   out_last     head entry is the final word of a burst
//   burst_done   registered one-cycle pulse after a last beat is accepted
//   busy         queue non-empty or a burst is partially popped
//
// Optional build macro FIFO_DRAIN_STATS_EN adds these ports:
//   beat_count   [31:0] accepted beats, wraps modulo 2^32
//   burst_count  [15:0] accepted last beats, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_drain_stage #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             burst_done,
    output logic             busy
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [15:0]      burst_count
`endif
);

    localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

    // Control state (reset)
    logic [1:0]       occ_q,        occ_d;
    logic [15:0]      pop_cnt_q,    pop_cnt_d;
    logic             burst_done_q, burst_done_d;

    // Queue storage (not reset; masked by occupancy on the outputs)
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic             last0_q, last0_d;
    logic             last1_q, last1_d;

    logic             pop_en;
    logic             accept;
    logic             pop_last;

    // Pop decision from registered occupancy only
    always_comb begin
        pop_en     = !rst && enable && !fifo_empty && (occ_q != 2'd2);
        fifo_rd_en = pop_en;
        pop_last   = (pop_cnt_q == LAST_CNT);
    end

    // Head presentation
    always_comb begin
        out_valid  = (occ_q != 2'd0);
        accept     = out_valid && out_ready;
        out_data   = out_valid ? data0_q : '0;
        out_last   = out_valid && last0_q;
        burst_done = burst_done_q;
        busy       = out_valid || (pop_cnt_q != 16'd0);
    end

    // Burst framing: the counter advances only on pops, so a stalled or
    // disabled burst simply resumes at the held count.
    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (pop_en) begin
            if (pop_last) begin
                pop_cnt_d = 16'd0;
            end else begin
                pop_cnt_d = pop_cnt_q + 16'd1;
            end
        end
    end

    // Queue update. Entry 0 is always the head. An accept shifts entry 1
    // forward; a pushed word lands in the first slot left free after that.
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        unique case ({pop_en, accept})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    data0_d = fifo_data;
                    last0_d = pop_last;
                end else begin
                    data1_d = fifo_data;
                    last1_d = pop_last;
                end
            end
            2'b01: begin
                occ_d   = occ_q - 2'd1;
                data0_d = data1_q;
                last0_d = last1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = fifo_data;
                    last0_d = pop_last;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = fifo_data;
                    last1_d = pop_last;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        burst_done_d = accept && out_last;
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q        <= 2'd0;
            pop_cnt_q    <= 16'd0;
            burst_done_q <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            pop_cnt_q    <= pop_cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

    // Queue data registers
    always_ff @(posedge clk) begin
        data0_q <= data0_d;
        data1_q <= data1_d;
        last0_q <= last0_d;
        last1_q <= last1_d;
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] beat_count_q,  beat_count_d;
    logic [15:0] burst_count_q, burst_count_d;

    always_comb begin
        beat_count_d  = beat_count_q;
        burst_count_d = burst_count_q;
        if (accept) begin
            beat_count_d = beat_count_q + 32'd1;
            if (out_last) begin
                burst_count_d = burst_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q  <= 32'd0;
            burst_count_q <= 16'd0;
        end else begin
            beat_count_q  <= beat_count_d;
            burst_count_q <= burst_count_d;
        end
    end

    always_comb begin
        beat_count  = beat_count_q;
        burst_count = burst_count_q;
    end
`endif

endmodule
